// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Brief    : Shared types and constants for the APB wait-state memory slave.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Number of bits in one byte lane of the data bus.
    localparam int BYTE_WIDTH = 8;

    // Transfer sequencing states of the slave.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RDY  = 2'd2
    } apb_state_e;

    // Bit width needed to index v entries, never less than one.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_array
//  Brief    : Word memory with byte-strobed synchronous write, combinational
//             read and asynchronous clear of every word.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             we_i,
    input  logic [IDX_WIDTH-1:0]             waddr_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wstrb_i,
    input  logic [IDX_WIDTH-1:0]             raddr_i,
    output logic [DATA_WIDTH-1:0]            rdata_o
);

    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear all words on reset; otherwise update only the strobed byte lanes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/apb_wait_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_wait_mem_slave
//  Brief    : APB slave backed by a word memory, inserting a fixed number of
//             access-phase wait states; upper words are read-only.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_wait_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2,
    parameter int RO_BASE     = 192
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [ADDR_WIDTH-1:0]            PADDR,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]            PRDATA,
    output logic                             PREADY,
    output logic                             PSLVERR
);

    localparam int NBYTES    = DATA_WIDTH / BYTE_WIDTH;
    localparam int OFF_WIDTH = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int IDX_WIDTH = clog2_min1(MEM_DEPTH);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_data_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (RO_BASE > MEM_DEPTH) begin : g_chk_ro_base
        $error("RO_BASE must not exceed MEM_DEPTH");
    end
    if (MEM_DEPTH > (2 ** (ADDR_WIDTH - OFF_WIDTH))) begin : g_chk_depth
        $error("MEM_DEPTH exceeds the addressable word range");
    end
    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_chk_wait
        $error("WAIT_STATES must be in 0..15");
    end

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  w_setup;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_misaligned;
    logic                  w_err;
    logic [IDX_WIDTH-1:0]  w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_mem_we;

    assign w_setup      = PSEL & ~PENABLE;
    assign w_word_idx   = PADDR >> OFF_WIDTH;
    assign w_misaligned = (PADDR & ADDR_WIDTH'(NBYTES - 1)) != '0;
    // Compare at 32 bits so a memory filling the whole address space cannot wrap.
    assign w_err        = w_misaligned
                        | (32'(w_word_idx) >= MEM_DEPTH)
                        | (PWRITE & (32'(w_word_idx) >= RO_BASE));
    assign w_mem_idx    = w_word_idx[IDX_WIDTH-1:0];

    // Completion is visible only while the master holds the access phase.
    assign PREADY   = (state_q == ST_RDY) & PSEL & PENABLE;
    assign PSLVERR  = PREADY & err_q;
    assign PRDATA   = prdata_q;
    assign w_mem_we = PREADY & PWRITE & ~err_q;

    // Next-state logic: sequencing, wait countdown, error capture, read data capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_setup) begin
                    err_d   = w_err;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RDY;
                    if (!PWRITE) begin
                        prdata_d = w_err ? '1 : w_mem_rdata;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: nothing gets committed.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RDY;
                    end
                end
            end
            ST_RDY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_n_i (PRESETn),
        .we_i    (w_mem_we),
        .waddr_i (w_mem_idx),
        .wdata_i (PWDATA),
        .wstrb_i (PSTRB),
        .raddr_i (w_mem_idx),
        .rdata_o (w_mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb_wait_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_wait_mem_slave
//  Brief    : Self-checking bench for apb_wait_mem_slave; instance 0 uses two
//             wait states, instance 1 uses none. A word-array model predicts
//             completion latency, error response and read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_wait_mem_slave;

    localparam int DEPTH = 256;
    localparam int RO    = 192;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  paddr;
    logic        penable, pwrite, psel0, psel1;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];
    int          ws [2] = '{2, 0};

    always #5 clk = ~clk;

    apb_wait_mem_slave #(.WAIT_STATES(2)) dut0 (
        .PCLK(clk), .PRESETn(rstn), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_wait_mem_slave #(.WAIT_STATES(0)) dut1 (
        .PCLK(clk), .PRESETn(rstn), .PADDR(paddr), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    task automatic drive_idle();
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
        end
    endtask

    // One APB transfer starting at a falling edge; returns at the falling edge
    // after completion with the bus still driven (back-to-back capable).
    task automatic xfer(input int d, input bit wr, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int waits);
        bit done;
        psel0 = (d == 0); psel1 = (d == 1); penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(negedge clk);
        penable = 1'b1; waits = 0; done = 0; rd = 'x; err = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (((d == 0) ? pready0 : pready1) === 1'b1) begin
                done = 1;
                err  = (d == 0) ? pslverr0 : pslverr1;
                rd   = (d == 0) ? prdata0 : prdata1;
            end else begin
                waits++;
            end
            @(negedge clk);
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL timeout: dut%0d addr %h no PREADY within 40 cycles", d, addr);
        end
    endtask

    // Transfer plus model prediction: expected error, PRDATA and memory update.
    task automatic ref_xfer(input int d, input bit wr, input logic [9:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rd, output logic err, output int waits,
                            output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = int'(addr) / 4;
        exp_err = (addr % 4 != 0) || (idx >= DEPTH) || (wr && idx >= RO);
        if (wr) exp_rd = last_rd[d];
        else    exp_rd = exp_err ? 32'hFFFF_FFFF : mdl[d][idx];
        xfer(d, wr, addr, wdata, strb, rd, err, waits);
        if (!wr) last_rd[d] = exp_rd;
        if (wr && !exp_err && idx < DEPTH) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rstn = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        checks++;
        if ({pready0, pslverr0, prdata0} !== 34'd0) begin
            errors++; $display("FAIL reset_dut0: got %h required 0", {pready0, pslverr0, prdata0});
        end
        checks++;
        if ({pready1, pslverr1, prdata1} !== 34'd0) begin
            errors++; $display("FAIL reset_dut1: got %h required 0", {pready1, pslverr1, prdata1});
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_write();
        logic [31:0] rd, erd; logic er, eer; int w;
        ref_xfer(0, 1, 10'h010, 32'h1234_5678, 4'hF, rd, er, w, erd, eer);
        checks++;
        if (w !== 2) begin errors++; $display("FAIL wr_waits: got %0d required 2", w); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL wr_slverr: got %b required 0", er); end
        checks++;
        if (rd !== erd) begin errors++; $display("FAIL wr_prdata_hold: got %h required %h", rd, erd); end
        ref_xfer(0, 0, 10'h010, 32'h0, 4'h0, rd, er, w, erd, eer);
        checks++;
        if (rd !== 32'h1234_5678) begin errors++; $display("FAIL full_readback: got %h required 12345678", rd); end
        checks++;
        if (w !== 2 || er !== 1'b0) begin errors++; $display("FAIL rd_timing: waits %0d err %b required 2/0", w, er); end
        drive_idle();
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd, erd; logic er, eer; int w;
        ref_xfer(0, 1, 10'h010, 32'hAABB_CCDD, 4'h5, rd, er, w, erd, eer);
        ref_xfer(0, 0, 10'h010, 32'h0, 4'hF, rd, er, w, erd, eer);
        checks++;
        if (rd !== 32'h12BB_56DD) begin errors++; $display("FAIL strobe_readback: got %h required 12BB56DD", rd); end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer; int w;
        ref_xfer(0, 1, 10'h320, 32'hFFFF_FFFF, 4'hF, rd, er, w, erd, eer);
        checks++;
        if (er !== 1'b1 || w !== 2) begin errors++; $display("FAIL ro_write_err: err %b waits %0d required 1/2", er, w); end
        ref_xfer(0, 0, 10'h320, 32'h0, 4'hF, rd, er, w, erd, eer);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL ro_unchanged: got %h err %b required 0/0", rd, er); end
        ref_xfer(0, 0, 10'h3FE, 32'h0, 4'hF, rd, er, w, erd, eer);
        checks++;
        if (er !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL misaligned_read: got %h err %b required FFFFFFFF/1", rd, er);
        end
        ref_xfer(0, 1, 10'h012, 32'h5555_5555, 4'hF, rd, er, w, erd, eer);
        checks++;
        if (er !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL misaligned_write: got %h err %b required FFFFFFFF/1", rd, er);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic er, eer; int w, w2;
        ref_xfer(1, 1, 10'h004, 32'h0000_00A5, 4'hF, rd, er, w, erd, eer);
        ref_xfer(1, 0, 10'h004, 32'h0, 4'h0, rd, er, w2, erd, eer);
        checks++;
        if (w !== 0 || w2 !== 0) begin errors++; $display("FAIL b2b_waits: got %0d,%0d required 0,0", w, w2); end
        checks++;
        if (rd !== 32'h0000_00A5 || er !== 1'b0) begin
            errors++; $display("FAIL b2b_readback: got %h err %b required 000000A5/0", rd, er);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic er, eer; int w;
        ref_xfer(0, 1, 10'h00C, 32'h1122_3344, 4'hF, rd, er, w, erd, eer);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h00C;
        pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #1;
        checks++;
        if (pready0 !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b required 0", pready0); end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        ref_xfer(0, 0, 10'h00C, 32'h0, 4'h0, rd, er, w, erd, eer);
        checks++;
        if (rd !== 32'h1122_3344 || w !== 2 || er !== 1'b0) begin
            errors++; $display("FAIL abort_unchanged: got %h waits %0d err %b required 11223344/2/0", rd, w, er);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer; int w;
        ref_xfer(0, 1, 10'h008, 32'hCAFE_F00D, 4'hF, rd, er, w, erd, eer);
        ref_xfer(0, 0, 10'h008, 32'h0, 4'h0, rd, er, w, erd, eer);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h008;
        pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (pready0 !== 1'b0 || prdata0 !== 32'h0) begin
            errors++; $display("FAIL reset_mid_outputs: pready %b prdata %h required 0/0", pready0, prdata0);
        end
        clear_model();
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        ref_xfer(0, 0, 10'h008, 32'h0, 4'h0, rd, er, w, erd, eer);
        checks++;
        if (rd !== 32'h0 || w !== 2 || er !== 1'b0) begin
            errors++; $display("FAIL reset_mid_readback: got %h waits %0d err %b required 0/2/0", rd, w, er);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd; logic er, eer; int w, d; logic [9:0] a; bit wr;
        for (int n = 0; n < 80; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 2) == 0) a[9:2] = 8'($urandom_range(0, 7));
            wd = $urandom;
            ref_xfer(d, wr, a, wd, 4'($urandom_range(0, 15)), rd, er, w, erd, eer);
            checks++;
            if (w !== ws[d] || er !== eer || rd !== erd) begin
                errors++;
                $display("FAIL random_%0d: dut%0d addr %h wr %b got waits %0d err %b data %h required %0d/%b/%h",
                         n, d, a, wr, w, er, rd, ws[d], eer, erd);
            end
            if ($urandom_range(0, 2) == 0) begin
                drive_idle();
                @(negedge clk);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_write();
        test_partial_strobe();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_wait_mem_slave.md
APB_WAIT_MEM_SLAVE -- requirements
Module: apb_wait_mem_slave

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 10, byte address width; DATA_WIDTH, default 32, data width (8/16/32/64); MEM_DEPTH, default 256, words; WAIT_STATES, default 2, access-phase wait cycles (0..15); RO_BASE, default 192, first read-only word index.
REQ-002 SHALL have ports: PCLK in 1 clock, rising edge; PRESETn in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports: PADDR in ADDR_WIDTH byte address; PSEL in 1; PENABLE in 1; PWRITE in 1 (1=write); PWDATA in DATA_WIDTH; PSTRB in DATA_WIDTH/8 byte enables.
REQ-004 SHALL have ports: PRDATA out DATA_WIDTH read data; PREADY out 1 transfer complete; PSLVERR out 1 transfer error.

Function
REQ-005 Setup phase = PSEL & ~PENABLE; access phase = PSEL & PENABLE.
REQ-006 Word index = PADDR >> log2(DATA_WIDTH/8); byte offset = PADDR low log2(DATA_WIDTH/8) bits.
REQ-007 SHALL evaluate error in setup phase and register it: misaligned (offset != 0), out-of-range (index >= MEM_DEPTH), or write with index >= RO_BASE.
REQ-008 FSM states IDLE, WAIT, RDY; IDLE -> WAIT on setup phase if WAIT_STATES>0, else IDLE -> RDY.
REQ-009 In setup, wait counter loads WAIT_STATES; in WAIT, counter decrements each access-phase cycle; WAIT -> RDY when counter reaches 1 and decrements.
REQ-010 RDY -> IDLE unconditionally after one cycle; back-to-back setup then detected in IDLE.
REQ-011 PREADY SHALL be (state==RDY) & access phase, combinational; exactly WAIT_STATES low-PREADY access cycles precede completion.
REQ-012 PSLVERR SHALL equal PREADY & registered error; 0 otherwise.
REQ-013 Write SHALL commit on rising edge where PREADY=1 and no error; only bytes with PSTRB[i]=1 update.
REQ-014 Erroneous write SHALL not modify memory.
REQ-015 PRDATA SHALL register in setup phase of a read: memory[index] if no error, all-ones if error; holds until next read setup.
REQ-016 Write setup SHALL not alter PRDATA.
REQ-017 PSEL deasserted in WAIT (abort) SHALL return FSM to IDLE with no memory update.
REQ-018 PSTRB SHALL be ignored on reads.

Reset
REQ-019 PRESETn low SHALL immediately force state IDLE, counter 0, error flag 0, PRDATA 0, all memory words 0; PREADY and PSLVERR therefore 0.
REQ-020 Reset mid-transfer SHALL abort it with no memory write; first post-reset transfer behaves normally.

Structure
REQ-021 Shared package apb_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RDY) and byte-width constant 8.
REQ-022 Memory SHALL be sub-module apb_mem_array: byte-strobed synchronous write port, combinational read port, async clear.
REQ-023 Parameter checks: DATA_WIDTH multiple of 8; RO_BASE <= MEM_DEPTH; MEM_DEPTH <= 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).

Verification
REQ-024 WAIT_STATES=2: write 0x1234_5678 to PADDR 0x010, PSTRB 0xF -> PREADY low 2 access cycles, high on 3rd, PSLVERR 0; readback of 0x010 returns 0x1234_5678.
REQ-025 Partial strobe: word 0x010 = 0x1234_5678, write 0xAABB_CCDD PSTRB 0x5 -> readback 0x12BB_56DD.
REQ-026 Write 0xFFFF_FFFF to index 200 (PADDR 0x320) -> PSLVERR=1 with PREADY, memory unchanged; read PADDR 0x3FE (misaligned) -> PSLVERR=1, PRDATA 0xFFFF_FFFF.
REQ-027 WAIT_STATES=0: back-to-back write 0x0000_00A5 then read at PADDR 0x004 -> each PREADY in first access cycle, read returns 0x0000_00A5.
REQ-028 Assert PRESETn low during WAIT of a write to 0x008 -> PREADY 0, PRDATA 0, word 0x008 reads 0 after reset.
REQ-029 Drop PSEL in WAIT during write to 0x00C -> FSM IDLE, word unchanged, next transfer completes normally.
